// File: rtl/stream_pkt_pkg.sv
// Shared constants for stream_packetizer: CSR word addresses, CTRL write-bit positions and
// CTRL read-back (status) field offsets, plus a helper that maps a programmed packet length to
// the length actually used for framing.
package stream_pkt_pkg;

  // CSR word addresses
  localparam logic [1:0] ADDR_PKT_LEN  = 2'd0;
  localparam logic [1:0] ADDR_CTRL     = 2'd1;
  localparam logic [1:0] ADDR_WORD_CNT = 2'd2;
  localparam logic [1:0] ADDR_PKT_CNT  = 2'd3;

  // CTRL write bits
  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_CLR_CNT_BIT = 1;

  // CTRL read-back layout
  localparam int unsigned STAT_ENABLE_BIT = 0;
  localparam int unsigned STAT_BUSY_BIT   = 1;
  localparam int unsigned STAT_EMPTY_BIT  = 2;
  localparam int unsigned STAT_FULL_BIT   = 3;
  localparam int unsigned STAT_HWM_LSB    = 8;
  localparam int unsigned STAT_LEVEL_LSB  = 16;
  localparam int unsigned STAT_FIELD_W    = 8;

  // A programmed length of 0 frames as single-word packets.
  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/stream_packetizer_if.sv
// Bus bundle for stream_packetizer: Avalon-MM CSR slave, Avalon-ST sink (asi_*) and
// Avalon-ST source (aso_*).
//   slave  : view of the packetizer (CSR slave, stream sink in, stream source out)
//   master : view of the environment driving it (CPU/bridge, upstream source, DMA sink)
interface stream_packetizer_if;

  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [1:0]  avs_address;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  logic        asi_valid;
  logic [31:0] asi_data;
  logic        asi_ready;

  logic        aso_valid;
  logic [31:0] aso_data;
  logic        aso_startofpacket;
  logic        aso_endofpacket;
  logic        aso_ready;

  modport slave (
    input  avs_write, avs_writedata, avs_read, avs_address,
    output avs_readdata, avs_readdatavalid,
    input  asi_valid, asi_data,
    output asi_ready,
    output aso_valid, aso_data, aso_startofpacket, aso_endofpacket,
    input  aso_ready
  );

  modport master (
    output avs_write, avs_writedata, avs_read, avs_address,
    input  avs_readdata, avs_readdatavalid,
    output asi_valid, asi_data,
    input  asi_ready,
    input  aso_valid, aso_data, aso_startofpacket, aso_endofpacket,
    output aso_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A word written at edge N is visible on rd_data_o
// (with empty_o low) right after edge N. Depth = 2**FIFO_AW.
//   clk, reset_n : clock, asynchronous active-low reset (discards contents)
//   wr_en_i      : push wr_data_i (ignored when full)
//   rd_en_i      : pop the head word (ignored when empty)
//   rd_data_o    : head word, don't-care when empty
//   full_o/empty_o/level_o : occupancy status, level in 0..2**FIFO_AW
module sync_fifo #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned DW      = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en_i,
  input  logic [DW-1:0]      wr_data_i,
  input  logic               rd_en_i,
  output logic [DW-1:0]      rd_data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   level_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FullLevel = {1'b1, {FIFO_AW{1'b0}}};

  logic [DW-1:0]      mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               wr_fire, rd_fire;

  assign full_o    = (level_q == FullLevel);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign wr_fire = wr_en_i & ~full_o;
  assign rd_fire = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    unique case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/stream_packetizer.sv
// Buffers result words from stream_processor in a FWFT FIFO and frames them into fixed-length
// packets (SOP/EOP) for the DMA write master. Packet length, enable, statistics and FIFO status
// are exposed over a 4-word Avalon-MM CSR slave with read latency 1.
//   clk, reset_n : single clock, asynchronous active-low reset
//   bus (slave)  : avs_* CSR slave, asi_* stream sink, aso_* framed stream source
// Build option: define STREAM_PACKETIZER_HWM_EN to keep a FIFO high-water mark reported in
// CTRL[15:8]; without it that field reads 0.
module stream_packetizer
  import stream_pkt_pkg::*;
#(
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [31:0] PKT_LEN_RST = 32'd256
) (
  input logic                 clk,
  input logic                 reset_n,
  stream_packetizer_if.slave  bus
);

  logic             fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_level;
  logic [31:0]      fifo_rd_data;
  logic [7:0]       level_byte;
  logic [7:0]       hwm;

  logic             asi_ready, aso_valid;
  logic             in_fire, out_fire;

  logic             enable_q, enable_d;
  logic [31:0]      pkt_len_q, pkt_len_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      idx_q, idx_d;
  logic [31:0]      cur_len;
  logic             sop, eop;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             readdatavalid_q;
  logic [31:0]      status;
  logic [31:0]      rd_mux;

  logic             csr_wr_len, csr_wr_ctrl, clr_cnt;

  // Ready depends on registered state only, so a pop at full cannot reopen it the same cycle.
  assign asi_ready = enable_q & ~fifo_full;
  assign aso_valid = ~fifo_empty;
  assign in_fire   = bus.asi_valid & asi_ready;
  assign out_fire  = aso_valid & bus.aso_ready;

  sync_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (32)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (in_fire),
    .wr_data_i (bus.asi_data),
    .rd_en_i   (out_fire),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign level_byte = 8'(fifo_level);

  assign bus.asi_ready         = asi_ready;
  assign bus.aso_valid         = aso_valid;
  assign bus.aso_data          = fifo_rd_data;
  assign bus.aso_startofpacket = sop;
  assign bus.aso_endofpacket   = eop;
  assign bus.avs_readdata      = readdata_q;
  assign bus.avs_readdatavalid = readdatavalid_q;

  // CSR write decode; clr_cnt is a pulse that exists only in the write cycle.
  assign csr_wr_len  = bus.avs_write & (bus.avs_address == ADDR_PKT_LEN);
  assign csr_wr_ctrl = bus.avs_write & (bus.avs_address == ADDR_CTRL);
  assign clr_cnt     = csr_wr_ctrl & bus.avs_writedata[CTRL_CLR_CNT_BIT];

  always_comb begin
    pkt_len_d = pkt_len_q;
    enable_d  = enable_q;
    if (csr_wr_len)  pkt_len_d = bus.avs_writedata;
    if (csr_wr_ctrl) enable_d  = bus.avs_writedata[CTRL_ENABLE_BIT];
  end

  // Framing. At index 0 the live PKT_LEN is used and captured into len_q, so a mid-packet
  // PKT_LEN write only takes effect from the next start of packet.
  always_comb begin
    cur_len = (idx_q == 32'd0) ? eff_len(pkt_len_q) : len_q;
    sop     = (idx_q == 32'd0);
    eop     = (idx_q == cur_len - 32'd1);
    len_d   = (idx_q == 32'd0) ? cur_len : len_q;
    idx_d   = idx_q;
    if (out_fire) idx_d = eop ? 32'd0 : idx_q + 32'd1;
  end

  // Statistics; a clear beats a same-cycle increment.
  always_comb begin
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (clr_cnt) begin
      word_cnt_d = 32'd0;
      pkt_cnt_d  = 32'd0;
    end else if (out_fire) begin
      word_cnt_d = word_cnt_q + 32'd1;
      if (eop) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

`ifdef STREAM_PACKETIZER_HWM_EN
  logic [7:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (clr_cnt)                  hwm_d = 8'd0;
    else if (level_byte > hwm_q)  hwm_d = level_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hwm_q <= 8'd0;
    else          hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`else
  assign hwm = 8'd0;
`endif

  always_comb begin
    status                                   = 32'd0;
    status[STAT_ENABLE_BIT]                  = enable_q;
    status[STAT_BUSY_BIT]                    = (idx_q != 32'd0);
    status[STAT_EMPTY_BIT]                   = fifo_empty;
    status[STAT_FULL_BIT]                    = fifo_full;
    status[STAT_HWM_LSB +: STAT_FIELD_W]     = hwm;
    status[STAT_LEVEL_LSB +: STAT_FIELD_W]   = level_byte;
  end

  always_comb begin
    unique case (bus.avs_address)
      ADDR_PKT_LEN:  rd_mux = pkt_len_q;
      ADDR_CTRL:     rd_mux = status;
      ADDR_WORD_CNT: rd_mux = word_cnt_q;
      ADDR_PKT_CNT:  rd_mux = pkt_cnt_q;
      default:       rd_mux = 32'd0;
    endcase
    readdata_d = bus.avs_read ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q        <= 1'b1;
      pkt_len_q       <= PKT_LEN_RST;
      len_q           <= eff_len(PKT_LEN_RST);
      idx_q           <= 32'd0;
      word_cnt_q      <= 32'd0;
      pkt_cnt_q       <= 32'd0;
      readdata_q      <= 32'd0;
      readdatavalid_q <= 1'b0;
    end else begin
      enable_q        <= enable_d;
      pkt_len_q       <= pkt_len_d;
      len_q           <= len_d;
      idx_q           <= idx_d;
      word_cnt_q      <= word_cnt_d;
      pkt_cnt_q       <= pkt_cnt_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= bus.avs_read;
    end
  end

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed self-checking bench for stream_packetizer (FIFO_AW=4, PKT_LEN_RST=256). Expected
// CTRL[15:8] follows STREAM_PACKETIZER_HWM_EN.
module tb_stream_packetizer;
  import stream_pkt_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stream_packetizer_if bus ();

  stream_packetizer #(
    .FIFO_AW     (4),
    .PKT_LEN_RST (32'd256)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] out_q [$];   // {sop, eop, data} per output handshake
  logic [31:0] rd;

  always @(negedge clk) begin
    if (reset_n && bus.aso_valid && bus.aso_ready)
      out_q.push_back({bus.aso_startofpacket, bus.aso_endofpacket, bus.aso_data});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hwm_exp(input int v);
`ifdef STREAM_PACKETIZER_HWM_EN
    return 32'(v) << 8;
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic csr_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read    = 1'b0;
    check_val({tag, "_rdvalid"}, {31'd0, bus.avs_readdatavalid}, 32'd1);
    check_val(tag, bus.avs_readdata, exp);
  endtask

  task automatic push(input logic [31:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      bus.asi_valid = 1'b1;
      bus.asi_data  = first + 32'(k);
      c = 0;
      while (!bus.asi_ready && c < 100) begin
        tick();
        c++;
      end
      if (!bus.asi_ready) begin
        check_val("push_timeout", {31'd0, bus.asi_ready}, 32'd1);
        break;
      end
      tick();
    end
    bus.asi_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int c = 0; c < 300 && out_q.size() < n; c++) tick();
    check_val(tag, 32'(out_q.size()), 32'(n));
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp_data,
                           input logic [1:0] exp_se);
    logic [33:0] w;
    if (out_q.size() == 0) begin
      check_val({tag, "_present"}, 32'(out_q.size()), 32'd1);
    end else begin
      w = out_q.pop_front();
      check_val({tag, "_data"}, w[31:0], exp_data);
      check_val({tag, "_sopeop"}, {30'd0, w[33:32]}, {30'd0, exp_se});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int accepted;
    logic will_accept;
    logic [1:0] se_tab [6];

    bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0; bus.avs_address = '0;
    bus.asi_valid = 1'b0; bus.asi_data = '0; bus.aso_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_asi_ready", {31'd0, bus.asi_ready}, 32'd1);
    check_val("rst_aso_valid", {31'd0, bus.aso_valid}, 32'd0);
    check_val("rst_sopeop", {30'd0, bus.aso_startofpacket, bus.aso_endofpacket}, 32'd2);
    check_val("rst_rdvalid", {31'd0, bus.avs_readdatavalid}, 32'd0);
    check_val("rst_rdata", bus.avs_readdata, 32'd0);
    reset_n = 1'b1;
    tick();
    csr_expect("rst_pkt_len", ADDR_PKT_LEN, 32'd256);
    csr_expect("rst_ctrl", ADDR_CTRL, 32'h0000_0005);
    csr_expect("rst_word_cnt", ADDR_WORD_CNT, 32'd0);
    csr_expect("rst_pkt_cnt", ADDR_PKT_CNT, 32'd0);
    tick();
    check_val("rdvalid_drop", {31'd0, bus.avs_readdatavalid}, 32'd0);

    // Packets of 4, words 1..8 streaming through
    csr_write(ADDR_PKT_LEN, 32'd4);
    bus.aso_ready = 1'b1;
    push(32'd1, 8);
    wait_out("len4_count", 8);
    for (int i = 0; i < 8; i++)
      pop_check("len4_w", 32'(i + 1), {(i % 4 == 0), (i % 4 == 3)});
    csr_expect("len4_word_cnt", ADDR_WORD_CNT, 32'd8);
    csr_expect("len4_pkt_cnt", ADDR_PKT_CNT, 32'd2);

    // Fill to full with the sink stalled
    bus.aso_ready = 1'b0;
    accepted = 0;
    bus.asi_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.asi_data = 32'd101 + 32'(accepted);
      will_accept = bus.asi_ready;
      tick();
      if (will_accept) accepted++;
    end
    check_val("full_accepted", 32'(accepted), 32'd16);
    check_val("full_asi_ready", {31'd0, bus.asi_ready}, 32'd0);
    csr_expect("full_ctrl", ADDR_CTRL, 32'h0010_0009 | hwm_exp(16));
    bus.asi_data  = 32'd117;
    bus.aso_ready = 1'b1;
    check_val("full_pop_ready", {31'd0, bus.asi_ready}, 32'd0);
    tick();
    bus.asi_valid = 1'b0;
    check_val("after_pop_ready", {31'd0, bus.asi_ready}, 32'd1);
    wait_out("full_count", 16);
    for (int i = 0; i < 16; i++)
      pop_check("full_w", 32'd101 + 32'(i), {(i % 4 == 0), (i % 4 == 3)});
    check_val("full_drained", {31'd0, bus.aso_valid}, 32'd0);
    csr_expect("full_word_cnt", ADDR_WORD_CNT, 32'd24);
    csr_expect("full_pkt_cnt", ADDR_PKT_CNT, 32'd6);

    // PKT_LEN change mid-packet applies from the next SOP
    csr_write(ADDR_PKT_LEN, 32'd3);
    bus.aso_ready = 1'b0;
    push(32'd201, 6);
    bus.aso_ready = 1'b1;
    tick();
    tick();
    bus.aso_ready = 1'b0;
    csr_write(ADDR_PKT_LEN, 32'd2);
    csr_expect("relen_ctrl", ADDR_CTRL, 32'h0004_0003 | hwm_exp(16));
    bus.aso_ready = 1'b1;
    wait_out("relen_count", 6);
    se_tab = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 6; i++)
      pop_check("relen_w", 32'd201 + 32'(i), se_tab[i]);
    csr_expect("relen_ctrl2", ADDR_CTRL, 32'h0000_0007 | hwm_exp(16));
    csr_expect("relen_word_cnt", ADDR_WORD_CNT, 32'd30);
    csr_expect("relen_pkt_cnt", ADDR_PKT_CNT, 32'd8);

    // Disable with words queued: input closes, output drains
    bus.aso_ready = 1'b0;
    push(32'd301, 5);
    csr_write(ADDR_CTRL, 32'd0);
    check_val("dis_asi_ready", {31'd0, bus.asi_ready}, 32'd0);
    bus.asi_valid = 1'b1;
    bus.asi_data  = 32'd999;
    tick();
    tick();
    bus.asi_valid = 1'b0;
    bus.aso_ready = 1'b1;
    wait_out("dis_count", 5);
    for (int i = 0; i < 5; i++)
      pop_check("dis_w", 32'd301 + 32'(i), (i % 2 == 0) ? 2'b01 : 2'b10);
    repeat (3) tick();
    check_val("dis_no_extra", 32'(out_q.size()), 32'd0);
    csr_expect("dis_ctrl", ADDR_CTRL, 32'h0000_0004 | hwm_exp(16));
    csr_expect("dis_word_cnt", ADDR_WORD_CNT, 32'd35);
    csr_expect("dis_pkt_cnt", ADDR_PKT_CNT, 32'd11);
    csr_write(ADDR_CTRL, 32'd3);
    check_val("en_asi_ready", {31'd0, bus.asi_ready}, 32'd1);
    csr_expect("clr_word_cnt", ADDR_WORD_CNT, 32'd0);
    csr_expect("clr_pkt_cnt", ADDR_PKT_CNT, 32'd0);
    csr_expect("clr_ctrl", ADDR_CTRL, 32'h0000_0005);

    // High-water mark: fill to 9, drain, then clear
    bus.aso_ready = 1'b0;
    push(32'd401, 9);
    bus.aso_ready = 1'b1;
    wait_out("hwm_count", 9);
    out_q.delete();
    csr_expect("hwm_ctrl", ADDR_CTRL, 32'h0000_0007 | hwm_exp(9));
    csr_write(ADDR_CTRL, 32'd3);
    csr_expect("hwm_clr_ctrl", ADDR_CTRL, 32'h0000_0007);

    // Reset with words queued
    bus.aso_ready = 1'b0;
    push(32'd501, 3);
    check_val("pre_rst_valid", {31'd0, bus.aso_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_valid", {31'd0, bus.aso_valid}, 32'd0);
    check_val("mid_rst_ready", {31'd0, bus.asi_ready}, 32'd1);
    check_val("mid_rst_sopeop", {30'd0, bus.aso_startofpacket, bus.aso_endofpacket}, 32'd2);
    tick();
    reset_n = 1'b1;
    tick();
    csr_expect("mid_rst_pkt_len", ADDR_PKT_LEN, 32'd256);
    csr_expect("mid_rst_ctrl", ADDR_CTRL, 32'h0000_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
